// File: rtl/slc3_mem_sequencer_if.sv
// Bus bundle between the SLC-3 datapath/control unit, the memory sequencer,
// the off-chip SRAM and the board switch/hex-display port.
interface slc3_mem_sequencer_if;
    logic        MEM_RD_REQ;
    logic        MEM_WR_REQ;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] MDR_In;
    logic        R;
    logic [15:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_in;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic [15:0] Switches;
    logic [15:0] HEX_DATA;

    modport slave (
        input  MEM_RD_REQ, MEM_WR_REQ, MAR, MDR, SRAM_DQ_in, Switches,
        output MDR_In, R, SRAM_ADDR, SRAM_DQ_out, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, HEX_DATA
    );

    modport master (
        output MEM_RD_REQ, MEM_WR_REQ, MAR, MDR, SRAM_DQ_in, Switches,
        input  MDR_In, R, SRAM_ADDR, SRAM_DQ_out, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, HEX_DATA
    );
endinterface

// File: rtl/slc3_mem_sequencer.sv
// SLC-3 memory-access sequencer: fixed wait-state SRAM cycles with a one-cycle ready pulse.
// Define SLC3_MEM_IO_MAP_EN to map the switch/hex-display port at IO_ADDR.
module slc3_mem_sequencer #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input logic                  Clk,
    input logic                  Reset,
    slc3_mem_sequencer_if.slave  bus
);

    if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_badWaitStates
        $error("slc3_mem_sequencer: WAIT_STATES must be within 1..15");
    end

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        DONE,
        REARM
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [3:0]  r_waitCnt;
    logic [15:0] r_mdrIn;
    logic        r_ready;
    logic [15:0] r_sramAddr;
    logic [15:0] r_sramDqOut;
    logic        r_ceN;
    logic        r_oeN;
    logic        r_weN;
    logic [15:0] r_hexData;
    logic        w_ioHit;
    logic        w_anyReq;

    assign w_anyReq = bus.MEM_RD_REQ | bus.MEM_WR_REQ;

`ifdef SLC3_MEM_IO_MAP_EN
    assign w_ioHit = (bus.MAR == IO_ADDR);
`else
    logic w_unusedIo;
    assign w_ioHit    = 1'b0;
    assign w_unusedIo = ^{bus.Switches, IO_ADDR};
`endif

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (bus.MEM_RD_REQ) begin
                    w_stateNext = w_ioHit ? DONE : RD_WAIT;
                end else if (bus.MEM_WR_REQ) begin
                    w_stateNext = w_ioHit ? DONE : WR_WAIT;
                end
            end
            RD_WAIT: if (r_waitCnt == 4'd0) w_stateNext = DONE;
            WR_WAIT: if (r_waitCnt == 4'd0) w_stateNext = DONE;
            DONE:    w_stateNext = REARM;
            REARM:   if (!w_anyReq) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Strobes and ready are registered from the next state so every output is a flop.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= IDLE;
            r_waitCnt   <= 4'd0;
            r_mdrIn     <= 16'h0000;
            r_ready     <= 1'b0;
            r_sramAddr  <= 16'h0000;
            r_sramDqOut <= 16'h0000;
            r_ceN       <= 1'b1;
            r_oeN       <= 1'b1;
            r_weN       <= 1'b1;
            r_hexData   <= 16'h0000;
        end else begin
            r_state <= w_stateNext;
            r_ready <= (w_stateNext == DONE);
            r_ceN   <= !((w_stateNext == RD_WAIT) || (w_stateNext == WR_WAIT));
            r_oeN   <= !(w_stateNext == RD_WAIT);
            r_weN   <= !(w_stateNext == WR_WAIT);
            case (r_state)
                IDLE: begin
                    if (w_anyReq && !w_ioHit) begin
                        r_sramAddr <= bus.MAR;
                        r_waitCnt  <= 4'(WAIT_STATES - 1);
                        if (!bus.MEM_RD_REQ) begin
                            r_sramDqOut <= bus.MDR;
                        end
                    end
`ifdef SLC3_MEM_IO_MAP_EN
                    else if (w_ioHit && bus.MEM_RD_REQ) begin
                        r_mdrIn <= bus.Switches;
                    end else if (w_ioHit && bus.MEM_WR_REQ) begin
                        r_hexData <= bus.MDR;
                    end
`endif
                end
                RD_WAIT: begin
                    if (r_waitCnt == 4'd0) begin
                        r_mdrIn <= bus.SRAM_DQ_in;
                    end else begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end
                WR_WAIT: begin
                    if (r_waitCnt != 4'd0) begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.MDR_In      = r_mdrIn;
    assign bus.R           = r_ready;
    assign bus.SRAM_ADDR   = r_sramAddr;
    assign bus.SRAM_DQ_out = r_sramDqOut;
    assign bus.SRAM_CE_N   = r_ceN;
    assign bus.SRAM_OE_N   = r_oeN;
    assign bus.SRAM_WE_N   = r_weN;
    assign bus.HEX_DATA    = r_hexData;

endmodule

// File: tb/tb_slc3_mem_sequencer.sv
// Scoreboard bench for slc3_mem_sequencer: stimulus pushes expected responses,
// a negedge monitor pops and compares on every R pulse. Honours SLC3_MEM_IO_MAP_EN.
module tb_slc3_mem_sequencer;

    localparam int W = 2;
`ifdef SLC3_MEM_IO_MAP_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] mdrIn;
        logic [15:0] hex;
        int          rCycle;
        int          oeCnt;
        int          weCnt;
    } exp_t;

    logic Clk;
    logic Reset;
    slc3_mem_sequencer_if bus ();

    slc3_mem_sequencer #(
        .WAIT_STATES (W),
        .IO_ADDR     (16'hFFFF)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          passes = 0;
    int          cycle = 0;
    int          issued = 0;
    int          rSeen = 0;
    exp_t        expQ[$];
    logic [15:0] refMem [0:65535];
    logic [15:0] sramMem [0:65535];
    logic [15:0] lastRead = 16'h0000;
    logic [15:0] hexModel = 16'h0000;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cycle <= cycle + 1;

    // SRAM model: combinational read while enabled, write sampled on each write-strobe edge.
    assign bus.SRAM_DQ_in = (!bus.SRAM_CE_N && !bus.SRAM_OE_N) ? sramMem[bus.SRAM_ADDR] : 16'hDEAD;

    initial begin
        for (int i = 0; i < 65536; i++) sramMem[i] = 16'h0000;
        sramMem[16'h3000] = 16'h1234;
        forever begin
            @(posedge Clk);
            if (Reset && !bus.SRAM_CE_N && !bus.SRAM_WE_N) sramMem[bus.SRAM_ADDR] = bus.SRAM_DQ_out;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // Monitor: tallies strobe cycles between ready pulses and checks each pulse against the queue.
    int   oeCnt = 0;
    int   weCnt = 0;
    int   ceCnt = 0;
    logic prevR = 1'b0;
    always @(negedge Clk) begin
        exp_t e;
        if (!Reset) begin
            oeCnt = 0; weCnt = 0; ceCnt = 0; prevR = 1'b0;
        end else begin
            if (prevR) checkOutput("rPulseWidth", 32'(bus.R), 32'd0);
            if (!bus.SRAM_OE_N) oeCnt++;
            if (!bus.SRAM_WE_N) weCnt++;
            if (!bus.SRAM_CE_N) ceCnt++;
            if (bus.R) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedR", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("mdrIn", 32'(bus.MDR_In), 32'(e.mdrIn));
                    checkOutput("hexData", 32'(bus.HEX_DATA), 32'(e.hex));
                    checkOutput("rLatency", 32'(cycle), 32'(e.rCycle));
                    checkOutput("oeCycles", 32'(oeCnt), 32'(e.oeCnt));
                    checkOutput("weCycles", 32'(weCnt), 32'(e.weCnt));
                    checkOutput("ceCycles", 32'(ceCnt), 32'(e.oeCnt + e.weCnt));
                end
                rSeen++;
                oeCnt = 0; weCnt = 0; ceCnt = 0;
            end
            prevR = bus.R;
        end
    end

    // Issues one request, predicts its response from the memory model, then waits for completion.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] mar,
                                 input logic [15:0] mdr, input logic [15:0] sw, input int hold);
        exp_t e;
        logic isIo;
        int   guard;
        @(negedge Clk);
        isIo = IO_EN && (mar == 16'hFFFF);
        if (rd) begin
            lastRead = isIo ? sw : refMem[mar];
        end else if (isIo) begin
            hexModel = mdr;
        end else begin
            refMem[mar] = mdr;
        end
        e.mdrIn  = lastRead;
        e.hex    = hexModel;
        e.rCycle = cycle + 1 + (isIo ? 0 : W);
        e.oeCnt  = (rd && !isIo) ? W : 0;
        e.weCnt  = (!rd && !isIo) ? W : 0;
        expQ.push_back(e);
        bus.MEM_RD_REQ = rd;
        bus.MEM_WR_REQ = wr;
        bus.MAR        = mar;
        bus.MDR        = mdr;
        bus.Switches   = sw;
        issued++;
        for (int k = 0; k < hold; k++) begin
            @(negedge Clk);
            bus.MAR      = 16'($urandom);
            bus.MDR      = 16'($urandom);
            bus.Switches = 16'($urandom);
        end
        bus.MEM_RD_REQ = 1'b0;
        bus.MEM_WR_REQ = 1'b0;
        guard = 0;
        while (rSeen < issued && guard < 60) begin
            @(negedge Clk);
            guard++;
        end
        checkOutput("respTimeout", 32'(rSeen >= issued), 32'd1);
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        logic [15:0] mar;
        int          op;
        for (int i = 0; i < 65536; i++) refMem[i] = 16'h0000;
        refMem[16'h3000] = 16'h1234;
        bus.MEM_RD_REQ = 1'b0;
        bus.MEM_WR_REQ = 1'b0;
        bus.MAR        = 16'h0000;
        bus.MDR        = 16'h0000;
        bus.Switches   = 16'h0000;
        Reset          = 1'b0;
        #23;
        checkOutput("rstMdrIn", 32'(bus.MDR_In), 32'd0);
        checkOutput("rstR", 32'(bus.R), 32'd0);
        checkOutput("rstAddr", 32'(bus.SRAM_ADDR), 32'd0);
        checkOutput("rstDqOut", 32'(bus.SRAM_DQ_out), 32'd0);
        checkOutput("rstHex", 32'(bus.HEX_DATA), 32'd0);
        checkOutput("rstStrobes", 32'({bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N}), 32'h7);
        @(negedge Clk);
        #3 Reset = 1'b1;

        // Abort a read in its first wait cycle: strobes must release at once and no R appears.
        @(negedge Clk);
        bus.MEM_RD_REQ = 1'b1;
        bus.MAR        = 16'h3000;
        @(negedge Clk);
        checkOutput("abortOeActive", 32'(bus.SRAM_OE_N), 32'd0);
        #2 Reset = 1'b0;
        #1;
        checkOutput("abortStrobes", 32'({bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N}), 32'h7);
        checkOutput("abortR", 32'(bus.R), 32'd0);
        checkOutput("abortMdrIn", 32'(bus.MDR_In), 32'd0);
        bus.MEM_RD_REQ = 1'b0;
        @(negedge Clk);
        #3 Reset = 1'b1;
        repeat (4) @(negedge Clk);

        applyStimulus(1'b1, 1'b0, 16'h3000, 16'h0000, 16'h0000, 1);
        applyStimulus(1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'h0000, 10);
        applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000, 2);
        applyStimulus(1'b1, 1'b1, 16'h0010, 16'h5555, 16'h0000, 3);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1);
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h00A5, 16'h0000, 1);
        applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0321, 1);

        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 3);
            case ($urandom_range(0, 5))
                0:       mar = 16'h3000;
                1:       mar = 16'h0040;
                2:       mar = 16'h0010;
                3:       mar = 16'hFFFF;
                default: mar = 16'h0100 + 16'($urandom_range(0, 7));
            endcase
            applyStimulus(op != 1, op == 1 || op == 2, mar, 16'($urandom), 16'($urandom),
                          $urandom_range(1, W + 6));
        end

        checkOutput("pendingQueue", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/slc3_mem_sequencer.md
# slc3_mem_sequencer

Memory-access sequencer for the SLC-3 core, sitting directly downstream of the datapath's MAR/MDR registers and upstream of the off-chip SRAM and board I/O. It accepts level-sensitive read/write requests from the control unit and runs a fixed wait-state SRAM cycle. It returns read data on `MDR_In`, which the datapath muxes into MDR when `MIO_EN` is high, together with a one-cycle ready pulse. It optionally decodes a memory-mapped switch/hex-display port.

## Interface
Parameters:
- `WAIT_STATES`, default 2: SRAM access wait cycles. Legal range 1..15; any value outside it is a compile-time error.
- `IO_ADDR`, default 16'hFFFF: memory-mapped I/O address. Used only when the I/O feature is compiled in.

Ports:
- `Clk`  in  1  system clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `MEM_RD_REQ`  in  1  read request, level-sensitive.
- `MEM_WR_REQ`  in  1  write request, level-sensitive.
- `MAR`  in  16  access address.
- `MDR`  in  16  write data.
- `MDR_In`  out  16  read data returned to the datapath.
- `R`  out  1  ready; one-cycle pulse marking access completion.
- `SRAM_ADDR`  out  16  registered SRAM address.
- `SRAM_DQ_in`  in  16  SRAM read data.
- `SRAM_DQ_out`  out  16  registered SRAM write data.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`  out  1 each  active-low SRAM strobes.
- `Switches`  in  16  board switch input.
- `HEX_DATA`  out  16  hex-display register.

## Operation
- FSM states and transitions:
  - IDLE: no access in progress.
  - RD_WAIT: SRAM read in progress.
  - WR_WAIT: SRAM write in progress.
  - DONE: access complete.
  - REARM: waiting for requests to drop.
- In IDLE, at each edge:
  - `MEM_RD_REQ`=1: latch `MAR` into `SRAM_ADDR`, load wait counter with `WAIT_STATES`-1, go to RD_WAIT.
  - `MEM_WR_REQ`=1 (with `MEM_RD_REQ`=0): latch `MAR` into `SRAM_ADDR` and `MDR` into `SRAM_DQ_out`, load the counter, go to WR_WAIT.
  - Both requests high: read wins; the write is ignored and not queued.
- RD_WAIT:
  - `SRAM_CE_N`=0, `SRAM_OE_N`=0.
  - Counter decrements each cycle.
  - On the edge where the counter is 0, capture `SRAM_DQ_in` into `MDR_In` and go to DONE.
- WR_WAIT:
  - `SRAM_CE_N`=0, `SRAM_WE_N`=0; address and data held stable from registers.
  - Counter decrements each cycle; at 0, go to DONE.
- DONE: `R`=1 for exactly this cycle, all strobes high, then go to REARM.
- REARM: stay until both requests are 0 at an edge, then go to IDLE. A request held high across states therefore produces exactly one access.
- Requests and `MAR`/`MDR` changes during RD_WAIT, WR_WAIT or DONE are ignored; the access uses the values latched in IDLE.
- `MDR_In` holds its last captured value until the next completed read. Writes never change it.

## Timing
- Reset values (asserted asynchronously, immediately on `Reset`=0):
  - FSM state IDLE, wait counter 0.
  - `MDR_In`=0, `R`=0, `SRAM_ADDR`=0, `SRAM_DQ_out`=0, `HEX_DATA`=0.
  - `SRAM_CE_N`=`SRAM_OE_N`=`SRAM_WE_N`=1.
- Reset mid-access: all strobes deassert asynchronously, the access is aborted, and no `R` pulse is produced.
- SRAM access latency: the request is sampled at edge E0. Strobes are active during the `WAIT_STATES` cycles following E0. `R` is high in the cycle after edge E0+`WAIT_STATES`, with `MDR_In` valid in that same cycle.
- Minimum spacing between accepted requests: `WAIT_STATES`+3 cycles (wait cycles, DONE, REARM, IDLE).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SLC3_MEM_IO_MAP_EN` defined:
  - Read of `IO_ADDR`: no SRAM strobes. `Switches` is captured into `MDR_In` at the IDLE edge, and the FSM goes directly to DONE (`R` in the cycle after E0).
  - Write of `IO_ADDR`: `HEX_DATA` <= `MDR` at the IDLE edge, no strobes, FSM goes directly to DONE.
- `SLC3_MEM_IO_MAP_EN` undefined:
  - `IO_ADDR` is an ordinary SRAM location.
  - `HEX_DATA` stays 0 and `Switches` is unused.

## Test plan
- Read, `WAIT_STATES`=2: SRAM model returns 16'h1234 at 16'h3000; pulse `MEM_RD_REQ` with `MAR`=16'h3000 -> `SRAM_OE_N` low for 2 cycles, `R` high in the 3rd cycle after E0, `MDR_In`=16'h1234.
- Write: `MAR`=16'h0040, `MDR`=16'hBEEF, `MEM_WR_REQ` held high 10 cycles -> `SRAM_WE_N` low exactly 2 cycles with `SRAM_DQ_out`=16'hBEEF, exactly one `R` pulse, `MDR_In` unchanged.
- Both requests high together at `MAR`=16'h0010 -> read occurs, `SRAM_WE_N` never low, SRAM content unchanged.
- Reset driven low during the 1st RD_WAIT cycle -> strobes high immediately, no `R` pulse, `MDR_In`=0, FSM back to IDLE.
- With `SLC3_MEM_IO_MAP_EN`: write 16'h00A5 to 16'hFFFF, then read 16'hFFFF with `Switches`=16'h0321 -> `HEX_DATA`=16'h00A5, `MDR_In`=16'h0321, each `R` pulse one cycle after E0, no SRAM strobes.
- Without `SLC3_MEM_IO_MAP_EN`: same sequence -> SRAM strobes occur, read returns 16'h00A5, `HEX_DATA` stays 0.
